shift_reg_seq: RTL
==================

# shift_reg_seq

Parametrised successor to the processor's plain enable-gated data registers. Holds a WIDTH-bit word, loads it in parallel, and on request performs a multi-cycle sequence of single-bit shifts or rotates, one per clock, with busy/done status. It serves multiply/divide sequencing and the shift/rotate instructions, sitting between the internal data bus and the ALU operand registers.

## Interface
- WIDTH, 16: data width in bits (≥ 2)
- CNT_W, $clog2(WIDTH+1): width of the shift-amount field and the internal counter
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous active-low reset
- load  in  1  parallel load of `in` (honoured only when not busy)
- in  in  WIDTH  parallel load data
- start  in  1  begin a shift sequence (honoured only when not busy)
- op  in  2  shift kind, sampled with start: 00 SHL, 01 SHR (logical), 10 SAR (arithmetic), 11 ROR (rotate right)
- amount  in  CNT_W  number of shifts, sampled with start
- ser_in  in  1  serial fill bit for SHL/SHR, sampled every shift cycle
- out  out  WIDTH  register contents
- ser_out  out  1  last bit shifted or rotated out (registered)
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse after the final shift

## Operation
- FSM states: IDLE, SHIFT, DONE. DONE lasts exactly one cycle, then IDLE.
- In IDLE or DONE: load=1 → out ← in (start ignored that cycle). Otherwise start=1 → latch op, cnt ← min(amount, WIDTH); next state SHIFT if cnt>0, else DONE.
- In SHIFT, every cycle: apply one shift, cnt ← cnt−1; when cnt reaches 0, next state DONE. load and start are ignored while busy.
- Shift rules (W = WIDTH):
  - SHL: out ← {out[W−2:0], ser_in}, ser_out ← out[W−1]
  - SHR: out ← {ser_in, out[W−1:1]}, ser_out ← out[0]
  - SAR: out ← {out[W−1], out[W−1:1]}, ser_out ← out[0]
  - ROR: out ← {out[0], out[W−1:1]}, ser_out ← out[0]; ser_in is ignored.
- amount > WIDTH saturates to WIDTH, for example for WIDTH=16, CNT_W=5.
- ser_out changes only on shift cycles. It holds its value across load and idle cycles.
- busy = (state==SHIFT). done = (state==DONE).

## Timing
- Reset values: out=0, ser_out=0, busy=0, done=0, state IDLE, cnt=0.
- Reset is asynchronous. Asserting it mid-sequence aborts immediately to the reset values. There is no partial result.
- Load latency: out shows `in` the cycle after the load edge.
- Start at edge t with amount N>0:
  - busy is high during cycles t+1 … t+N
  - out updates at each of those N edges
  - done is high in cycle t+N+1
- Start with amount 0: done is high in cycle t+1, out is unchanged, busy never rises.
- Back-to-back: a start or load in the DONE cycle is accepted, so the minimum gap between sequences is one cycle.

## Structure
- Shared package shift_pkg holds:
  - op encodings as a 2-bit enum: SHL, SHR, SAR, ROR
  - FSM state enum: IDLE, SHIFT, DONE
- Storage is WIDTH instances of the existing enable-gated ffd cell, with `en` driven by (load accepted) | busy.
- One combinational sub-module, shift_mux (WIDTH param), computes the next word and the shifted-out bit from out, op, ser_in.
- FSM, counter and op latch live in the top.

## Test plan
- Reset: assert rst_b=0 mid-cycle → out=0x0000, ser_out=0, busy=0, done=0 immediately.
- Load 0x8001, then SHL with amount=3 and ser_in=1 → busy for 3 cycles, out sequence 0x0003, 0x000F… check each step: 0x0003, 0x0007, 0x000F. Final ser_out=0. done pulses exactly 1 cycle, 4 cycles after start.
- Arithmetic and logical right shifts, 4 shifts each:
  - load 0x8000, SAR amount=4 → out=0xF800, ser_out=0
  - load 0x8000, SHR amount=4 with ser_in=0 → out=0x0800
- Rotate and saturation:
  - load 0x0001, ROR amount=1 → out=0x8000, ser_out=1
  - then ROR amount=20 → saturates to 16: busy exactly 16 cycles, out=0x8000 again
- Boundaries:
  - start amount=0 → done next cycle, out unchanged, busy stays 0
  - load=1 and start=1 in the same cycle → only the load happens
  - load 0xFFFF while busy → ignored
  - start in the DONE cycle → accepted
- Reset mid-sequence: SHL amount=10, drop rst_b at the 5th busy cycle → all outputs return to reset values. After release, a new load/start works normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift/rotate register: operation kinds and sequencer states.
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    SAR = 2'b10,
    ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/ffd.sv
// Enable-gated D flip-flop, the basic storage cell of the data registers.
// Async active-low reset clears q; q follows d on the rising edge when en is high.
module ffd (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)  q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shift_mux.sv
// Combinational single-step shifter: next word and the bit leaving it.
// Zero latency; no flow control.
module shift_mux
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  op_t              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt,
  output logic             bit_out
);

  always_comb begin
    nxt     = cur;
    bit_out = cur[0];
    case (op)
      SHL: begin
        nxt     = {cur[WIDTH-2:0], ser_in};
        bit_out = cur[WIDTH-1];
      end
      SHR:     nxt = {ser_in, cur[WIDTH-1:1]};
      SAR:     nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      ROR:     nxt = {cur[0], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Loadable WIDTH-bit register that runs multi-cycle shift/rotate sequences, one step per clock.
// Load visible next cycle; load/start are ignored while busy, done pulses one cycle after the last step.
module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_sat;
  logic             load_ok;
  logic             en;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] d;
  logic             bit_out;

  assign load_ok = load && (state != SHIFT);
  assign en      = load_ok | busy;
  assign d       = load_ok ? in : nxt;
  assign amt_sat = (amount > MAX_CNT) ? MAX_CNT : amount;

  shift_mux #(.WIDTH(WIDTH)) u_mux (
    .cur     (out),
    .op      (op_q),
    .ser_in  (ser_in),
    .nxt     (nxt),
    .bit_out (bit_out)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ffd u_ffd (
      .clk   (clk),
      .rst_b (rst_b),
      .en    (en),
      .d     (d[i]),
      .q     (out[i])
    );
  end

  // ser_out only moves on shift steps, so it survives loads and idle cycles.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    ser_out <= 1'b0;
    else if (busy) ser_out <= bit_out;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      op_q  <= SHL;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
          if (!load && start) begin
            op_q <= op_t'(op);
            cnt  <= amt_sat;
            if (amt_sat != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
